// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline sequencer: stall vector encodings,
// FSM state codes, default address width and the NOP PC.
package pipe_ctrl_pkg;

  localparam int DefAddrW = 32;

  // PC value driven whenever no redirect is being presented.
  localparam logic [DefAddrW-1:0] ZeroWord = '0;

  // Stall vector: bit0 pc, 1 if, 2 id, 3 ex, 4 mem, 5 wb; 1 = hold register.
  localparam logic [5:0] StallNone = 6'b000000;
  localparam logic [5:0] StallIf   = 6'b000011;
  localparam logic [5:0] StallId   = 6'b000111;
  localparam logic [5:0] StallEx   = 6'b001111;
  localparam logic [5:0] StallMem  = 6'b011111;
  localparam logic [5:0] StallAll  = 6'b111111;

  typedef enum logic [1:0] {
    StRun   = 2'd0,
    StPend  = 2'd1,
    StFlush = 2'd2
  } pc_state_e;

endpackage

// File: rtl/pipe_ctrl_stall_prio_enc.sv
// Combinational priority encoder: four per-stage stall requests into the
// 6-bit stall vector. The deepest requesting stage freezes itself and
// everything upstream of it.
module stall_prio_enc
  import pipe_ctrl_pkg::*;
(
  input  logic       req_if_i,
  input  logic       req_id_i,
  input  logic       req_ex_i,
  input  logic       req_mem_i,
  output logic [5:0] stall_o
);

  // Highest requesting stage wins.
  always_comb begin
    stall_o = StallNone;
    if (req_mem_i) begin
      stall_o = StallMem;
    end else if (req_ex_i) begin
      stall_o = StallEx;
    end else if (req_id_i) begin
      stall_o = StallId;
    end else if (req_if_i) begin
      stall_o = StallIf;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Central pipeline sequencer for the 5-stage core. Produces the stall
// vector, schedules exception/eret redirects as a one-cycle flush pulse
// (deferred while a memory access is outstanding), and keeps a saturating
// stall-cycle counter plus a sticky stall watchdog for debug.
//
// Request semantics: every request input is a level sampled on each rising
// edge; there is no acknowledge. A redirect (excp_req/eret_req) is accepted
// only in RUN and is taken on the same edge it is sampled; requests seen in
// PEND or FLUSH are dropped, so the source must not rely on them being queued.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int ADDR_W      = DefAddrW,
  parameter int CNT_W       = 32,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stallreq_if,
  input  logic              stallreq_id,
  input  logic              stallreq_ex,
  input  logic              stallreq_mem,
  input  logic              excp_req,
  input  logic [ADDR_W-1:0] excp_vec,
  input  logic              eret_req,
  input  logic [ADDR_W-1:0] epc_i,
  output logic [5:0]        stall,
  output logic              flush,
  output logic [ADDR_W-1:0] new_pc,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic              stall_timeout,
  output pc_state_e         dbg_state_o
);

  localparam int WdW = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT_CYC - 1);

  pc_state_e         state_q, state_d;
  logic [ADDR_W-1:0] tgt_q, tgt_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [WdW-1:0]    wd_q;
  logic              timeout_q;

  logic [5:0]        dec_stall;
  logic [5:0]        stall_raw;
  logic              flush_raw;
  logic [ADDR_W-1:0] new_pc_raw;

  stall_prio_enc u_prio (
    .req_if_i  (stallreq_if),
    .req_id_i  (stallreq_id),
    .req_ex_i  (stallreq_ex),
    .req_mem_i (stallreq_mem),
    .stall_o   (dec_stall)
  );

  // Next-state and raw outputs of the redirect sequencer.
  always_comb begin
    state_d    = state_q;
    tgt_d      = tgt_q;
    stall_raw  = dec_stall;
    flush_raw  = 1'b0;
    new_pc_raw = ADDR_W'(ZeroWord);
    case (state_q)
      StRun: begin
        if (excp_req || eret_req) begin
          tgt_d = excp_req ? excp_vec : epc_i;
          if (stallreq_mem) begin
            stall_raw = StallMem;
            state_d   = StPend;
          end else begin
            stall_raw = StallAll;
            state_d   = StFlush;
          end
        end
      end
      StPend: begin
        // Hold everything up to mem until the access drains; the first
        // captured target is kept and new redirects are not looked at.
        stall_raw = StallMem;
        if (!stallreq_mem) begin
          stall_raw = StallAll;
          state_d   = StFlush;
        end
      end
      StFlush: begin
        stall_raw  = StallNone;
        flush_raw  = 1'b1;
        new_pc_raw = tgt_q;
        state_d    = StRun;
      end
      default: begin
        state_d = StRun;
      end
    endcase
  end

  // State, target, performance counter and watchdog registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StRun;
      tgt_q     <= '0;
      cnt_q     <= '0;
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      if (stall_raw[0] && (cnt_q != '1)) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if ((state_q == StRun) && (stall_raw != StallNone)) begin
        if (wd_q == WdLast) begin
          timeout_q <= 1'b1;
        end else begin
          wd_q <= wd_q + 1'b1;
        end
      end else begin
        wd_q <= '0;
      end
    end
  end

  // Reset forces every output quiet, even before the first edge.
  always_comb begin
    stall         = rst ? StallNone : stall_raw;
    flush         = rst ? 1'b0 : flush_raw;
    new_pc        = rst ? ADDR_W'(ZeroWord) : new_pc_raw;
    stall_cycles  = rst ? '0 : cnt_q;
    stall_timeout = rst ? 1'b0 : timeout_q;
    dbg_state_o   = state_q;
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Testbench for pipe_ctrl: directed scenarios plus randomized traffic
// checked against a behavioural model of the sequencing rules.
module tb_pipe_ctrl;

  localparam int ADDR_W  = 32;
  localparam int CNT_W   = 6;
  localparam int TIMEOUT = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
  logic              excp_req, eret_req;
  logic [ADDR_W-1:0] excp_vec, epc_i;
  logic [5:0]        stall;
  logic              flush;
  logic [ADDR_W-1:0] new_pc;
  logic [CNT_W-1:0]  stall_cycles;
  logic              stall_timeout;
  pipe_ctrl_pkg::pc_state_e dbg_state;

  pipe_ctrl #(.ADDR_W(ADDR_W), .CNT_W(CNT_W), .TIMEOUT_CYC(TIMEOUT)) dut (
    .clk           (clk),
    .rst           (rst),
    .stallreq_if   (stallreq_if),
    .stallreq_id   (stallreq_id),
    .stallreq_ex   (stallreq_ex),
    .stallreq_mem  (stallreq_mem),
    .excp_req      (excp_req),
    .excp_vec      (excp_vec),
    .eret_req      (eret_req),
    .epc_i         (epc_i),
    .stall         (stall),
    .flush         (flush),
    .new_pc        (new_pc),
    .stall_cycles  (stall_cycles),
    .stall_timeout (stall_timeout),
    .dbg_state_o   (dbg_state)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- reference model ----------------
  // Redirect bookkeeping as plain flags: a redirect waiting for memory,
  // a flush due this cycle, and the chosen target.
  bit          m_waiting;
  bit          m_flush_due;
  logic [31:0] m_tgt;
  int          m_cycles;
  int          m_streak;
  bit          m_timeout;

  // Expected and observed values of the cycle just sampled.
  logic [5:0]        e_stall, o_stall;
  logic              e_flush, o_flush;
  logic [ADDR_W-1:0] e_pc, o_pc;
  int                e_cycles, o_cycles;
  logic              e_timeout, o_timeout;

  task automatic model_cycle();
    int n;
    e_cycles  = m_cycles;
    e_timeout = m_timeout;
    e_flush   = 1'b0;
    e_pc      = '0;
    e_stall   = 6'd0;
    if (rst) begin
      e_cycles    = 0;
      e_timeout   = 1'b0;
      m_waiting   = 1'b0;
      m_flush_due = 1'b0;
      m_tgt       = '0;
      m_cycles    = 0;
      m_streak    = 0;
      m_timeout   = 1'b0;
    end else begin
      if (m_flush_due) begin
        e_flush     = 1'b1;
        e_pc        = m_tgt;
        m_flush_due = 1'b0;
        m_streak    = 0;
      end else if (m_waiting) begin
        e_stall = stallreq_mem ? 6'b011111 : 6'b111111;
        if (!stallreq_mem) begin
          m_waiting   = 1'b0;
          m_flush_due = 1'b1;
        end
        m_streak = 0;
      end else begin
        // The deepest requesting stage freezes itself plus all stages before it.
        n = stallreq_mem ? 5 : stallreq_ex ? 4 : stallreq_id ? 3 : stallreq_if ? 2 : 0;
        e_stall = 6'((1 << n) - 1);
        if (excp_req || eret_req) begin
          m_tgt = excp_req ? excp_vec : epc_i;
          if (stallreq_mem) m_waiting = 1'b1;
          else begin
            e_stall     = 6'b111111;
            m_flush_due = 1'b1;
          end
        end
        if (e_stall != 0) begin
          if (m_streak + 1 >= TIMEOUT) m_timeout = 1'b1;
          m_streak++;
        end else begin
          m_streak = 0;
        end
      end
      if (e_stall[0] && m_cycles < CNT_MAX) m_cycles++;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    stallreq_if = 0; stallreq_id = 0; stallreq_ex = 0; stallreq_mem = 0;
    excp_req = 0; eret_req = 0; excp_vec = '0; epc_i = '0;
  endtask

  // One clock cycle: sample outputs mid-cycle, advance the model, step past the edge.
  task automatic tick();
    @(negedge clk);
    model_cycle();
    o_stall   = stall;
    o_flush   = flush;
    o_pc      = new_pc;
    o_cycles  = int'(stall_cycles);
    o_timeout = stall_timeout;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1;
    tick();
    rst = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1;
    stallreq_if = 1; stallreq_id = 1; stallreq_ex = 1; stallreq_mem = 1;
    excp_req = 1; eret_req = 1; excp_vec = 32'h20; epc_i = 32'h40;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++; if (o_stall !== 6'b0) begin n_fail++; $display("FAIL reset_stall cyc%0d got %b exp 000000", i, o_stall); end
      n_tests++; if (o_flush !== 1'b0) begin n_fail++; $display("FAIL reset_flush cyc%0d got %b exp 0", i, o_flush); end
      n_tests++; if (o_pc !== 32'h0) begin n_fail++; $display("FAIL reset_new_pc cyc%0d got %h exp 0", i, o_pc); end
      n_tests++; if (o_cycles !== 0) begin n_fail++; $display("FAIL reset_cycles cyc%0d got %0d exp 0", i, o_cycles); end
      n_tests++; if (o_timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout cyc%0d got %b exp 0", i, o_timeout); end
    end
    clear_inputs();
    rst = 0;
    tick();
    n_tests++; if (o_stall !== 6'b0) begin n_fail++; $display("FAIL post_reset_stall got %b exp 000000", o_stall); end
    n_tests++; if (o_cycles !== 0) begin n_fail++; $display("FAIL post_reset_cycles got %0d exp 0", o_cycles); end
  endtask

  task automatic test_priority();
    int c0;
    clear_inputs();
    stallreq_id = 1; stallreq_if = 1;
    tick();
    n_tests++; if (o_stall !== 6'b000111) begin n_fail++; $display("FAIL prio_id_if got %b exp 000111", o_stall); end
    stallreq_mem = 1;
    tick();
    n_tests++; if (o_stall !== 6'b011111) begin n_fail++; $display("FAIL prio_mem got %b exp 011111", o_stall); end
    clear_inputs();
    tick();
    c0 = o_cycles;
    n_tests++; if (o_stall !== 6'b0) begin n_fail++; $display("FAIL prio_idle got %b exp 000000", o_stall); end
    stallreq_ex = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_tests++; if (o_stall !== 6'b001111) begin n_fail++; $display("FAIL prio_ex cyc%0d got %b exp 001111", i, o_stall); end
    end
    stallreq_ex = 0;
    tick();
    n_tests++; if (o_cycles - c0 !== 5) begin n_fail++; $display("FAIL stall_cycles_delta got %0d exp 5", o_cycles - c0); end
  endtask

  task automatic test_excp_no_mem();
    clear_inputs();
    excp_req = 1; excp_vec = 32'h0000_0020;
    tick();
    n_tests++; if (o_stall !== 6'b111111) begin n_fail++; $display("FAIL excp_capture_stall got %b exp 111111", o_stall); end
    n_tests++; if (o_flush !== 1'b0) begin n_fail++; $display("FAIL excp_capture_flush got %b exp 0", o_flush); end
    clear_inputs();
    stallreq_mem = 1; stallreq_ex = 1;
    tick();
    n_tests++; if (o_flush !== 1'b1) begin n_fail++; $display("FAIL excp_flush got %b exp 1", o_flush); end
    n_tests++; if (o_pc !== 32'h20) begin n_fail++; $display("FAIL excp_new_pc got %h exp 00000020", o_pc); end
    n_tests++; if (o_stall !== 6'b0) begin n_fail++; $display("FAIL excp_flush_stall got %b exp 000000", o_stall); end
    clear_inputs();
    tick();
    n_tests++; if (o_flush !== 1'b0) begin n_fail++; $display("FAIL excp_after_flush got %b exp 0", o_flush); end
    n_tests++; if (o_pc !== 32'h0) begin n_fail++; $display("FAIL excp_after_pc got %h exp 0", o_pc); end
  endtask

  task automatic test_eret_mem();
    clear_inputs();
    stallreq_mem = 1; epc_i = 32'h0000_1234; excp_vec = 32'hdead_0000;
    for (int i = 0; i < 4; i++) begin
      eret_req = (i == 0);
      excp_req = (i == 2);
      tick();
      n_tests++; if (o_stall !== 6'b011111) begin n_fail++; $display("FAIL pend_stall cyc%0d got %b exp 011111", i, o_stall); end
      n_tests++; if (o_flush !== 1'b0) begin n_fail++; $display("FAIL pend_flush cyc%0d got %b exp 0", i, o_flush); end
    end
    clear_inputs();
    tick();
    n_tests++; if (o_stall !== 6'b111111) begin n_fail++; $display("FAIL pend_release_stall got %b exp 111111", o_stall); end
    tick();
    n_tests++; if (o_flush !== 1'b1) begin n_fail++; $display("FAIL eret_flush got %b exp 1", o_flush); end
    n_tests++; if (o_pc !== 32'h1234) begin n_fail++; $display("FAIL eret_new_pc got %h exp 00001234", o_pc); end
    tick();
    n_tests++; if (o_flush !== 1'b0) begin n_fail++; $display("FAIL eret_after_flush got %b exp 0", o_flush); end
  endtask

  task automatic test_both_and_rst_in_pend();
    clear_inputs();
    excp_req = 1; eret_req = 1; excp_vec = 32'h20; epc_i = 32'h40;
    tick();
    clear_inputs();
    tick();
    n_tests++; if (o_pc !== 32'h20) begin n_fail++; $display("FAIL both_new_pc got %h exp 00000020", o_pc); end
    n_tests++; if (o_flush !== 1'b1) begin n_fail++; $display("FAIL both_flush got %b exp 1", o_flush); end
    tick();
    eret_req = 1; epc_i = 32'h80; stallreq_mem = 1;
    tick();
    eret_req = 0;
    tick();
    rst = 1;
    tick();
    n_tests++; if (o_stall !== 6'b0) begin n_fail++; $display("FAIL rst_in_pend_stall got %b exp 000000", o_stall); end
    rst = 0; clear_inputs();
    for (int i = 0; i < 4; i++) begin
      tick();
      n_tests++; if (o_flush !== 1'b0) begin n_fail++; $display("FAIL rst_pend_no_flush cyc%0d got %b exp 0", i, o_flush); end
      n_tests++; if (o_stall !== 6'b0) begin n_fail++; $display("FAIL rst_pend_stall cyc%0d got %b exp 000000", i, o_stall); end
    end
  endtask

  task automatic test_watchdog();
    do_reset();
    stallreq_if = 1;
    repeat (TIMEOUT - 1) tick();
    stallreq_if = 0;
    repeat (3) tick();
    n_tests++; if (o_timeout !== 1'b0) begin n_fail++; $display("FAIL wd_short_stall got %b exp 0", o_timeout); end
    stallreq_if = 1;
    for (int i = 0; i < TIMEOUT; i++) begin
      tick();
      n_tests++; if (o_timeout !== 1'b0) begin n_fail++; $display("FAIL wd_early cyc%0d got %b exp 0", i, o_timeout); end
    end
    stallreq_if = 0;
    tick();
    n_tests++; if (o_timeout !== 1'b1) begin n_fail++; $display("FAIL wd_set got %b exp 1", o_timeout); end
    repeat (4) tick();
    n_tests++; if (o_timeout !== 1'b1) begin n_fail++; $display("FAIL wd_sticky got %b exp 1", o_timeout); end
  endtask

  task automatic test_saturation();
    do_reset();
    stallreq_if = 1;
    repeat (CNT_MAX + 8) tick();
    stallreq_if = 0;
    tick();
    n_tests++; if (o_cycles !== CNT_MAX) begin n_fail++; $display("FAIL cnt_saturate got %0d exp %0d", o_cycles, CNT_MAX); end
    n_tests++; if (o_cycles !== e_cycles) begin n_fail++; $display("FAIL cnt_saturate_model got %0d exp %0d", o_cycles, e_cycles); end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 300; i++) begin
      stallreq_if  = ($urandom_range(0, 3) == 0);
      stallreq_id  = ($urandom_range(0, 5) == 0);
      stallreq_ex  = ($urandom_range(0, 7) == 0);
      stallreq_mem = ($urandom_range(0, 3) == 0);
      excp_req     = ($urandom_range(0, 15) == 0);
      eret_req     = ($urandom_range(0, 15) == 0);
      excp_vec     = $urandom;
      epc_i        = $urandom;
      rst          = ($urandom_range(0, 99) == 0);
      tick();
      n_tests++; if (o_stall !== e_stall) begin n_fail++; $display("FAIL rnd_stall cyc%0d got %b exp %b", i, o_stall, e_stall); end
      n_tests++; if (o_flush !== e_flush) begin n_fail++; $display("FAIL rnd_flush cyc%0d got %b exp %b", i, o_flush, e_flush); end
      n_tests++; if (o_pc !== e_pc) begin n_fail++; $display("FAIL rnd_new_pc cyc%0d got %h exp %h", i, o_pc, e_pc); end
      n_tests++; if (o_cycles !== e_cycles) begin n_fail++; $display("FAIL rnd_cycles cyc%0d got %0d exp %0d", i, o_cycles, e_cycles); end
      n_tests++; if (o_timeout !== e_timeout) begin n_fail++; $display("FAIL rnd_timeout cyc%0d got %b exp %b", i, o_timeout, e_timeout); end
    end
    rst = 0;
    clear_inputs();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    clear_inputs();
    rst = 1;
    test_reset();
    test_priority();
    test_excp_no_mem();
    test_eret_mem();
    test_both_and_rst_in_pend();
    test_watchdog();
    test_saturation();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central pipeline sequencer for the 5-stage core: pc, if, id, ex, mem, wb.
- Turns per-stage stall requests into the 6-bit stall vector that freezes the stage registers, including the mem/wb pipeline register.
- Schedules exception and eret redirects as a one-cycle flush pulse plus a redirect PC, deferring them while a memory access is outstanding.
- Keeps a stall-cycle counter and a sticky stall-timeout flag for debug.

Parameters:
- ADDR_W, 32, width of redirect and exception PCs.
- CNT_W, 32, width of the stall-cycle performance counter.
- TIMEOUT_CYC, 1024, consecutive non-zero-stall cycles in RUN that set stall_timeout.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- stallreq_if  input  1  instruction fetch not ready.
- stallreq_id  input  1  load-use hazard.
- stallreq_ex  input  1  multi-cycle EX op (div/madd) busy.
- stallreq_mem  input  1  data memory access outstanding.
- excp_req  input  1  exception committed at MEM stage.
- excp_vec  input  ADDR_W  handler address for excp_req.
- eret_req  input  1  eret committed at MEM stage.
- epc_i  input  ADDR_W  return address for eret.
- stall  output  6  bit0 pc, 1 if, 2 id, 3 ex, 4 mem, 5 wb; 1 = hold stage register.
- flush  output  1  clear all stage registers to NOP.
- new_pc  output  ADDR_W  redirect target, valid while flush=1.
- stall_cycles  output  CNT_W  count of cycles with stall[0]=1.
- stall_timeout  output  1  sticky watchdog flag.

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk. The FSM goes to RUN and all registers clear. While rst=1, every output is forced to 0: stall=6'b000000, flush=0, new_pc=0, stall_cycles=0, stall_timeout=0.
- Stall decode is combinational and same-cycle. Highest requesting stage wins:
  - mem -> 6'b011111
  - ex -> 6'b001111
  - id -> 6'b000111
  - if -> 6'b000011
  - none -> 6'b000000
- FSM states: RUN, PEND, FLUSH.
- RUN: stall = decode.
  - If excp_req=1 or eret_req=1: capture the target into tgt_q. excp_req has priority, target excp_vec; otherwise epc_i.
  - Capture cycle with stallreq_mem=0: stall=6'b111111 for that cycle, next state FLUSH.
  - Capture cycle with stallreq_mem=1: stall=6'b011111, next state PEND.
- PEND: stall=6'b011111 every cycle.
  - excp_req/eret_req are ignored; the first captured target is kept.
  - When stallreq_mem samples 0: stall=6'b111111 that cycle, next state FLUSH.
- FLUSH: lasts exactly one cycle, then RUN.
  - flush=1, new_pc=tgt_q, stall=6'b000000.
  - All stall requests and redirect requests are ignored in this cycle.
- flush=0 and new_pc=0 in every state other than FLUSH.
- Latency:
  - Redirect with no memory stall: flush pulses exactly 1 cycle after the excp_req/eret_req sample.
  - With a memory stall: flush pulses 1 cycle after stallreq_mem is first sampled low in PEND.
- stall_cycles: increments every cycle in which the stall output has bit0=1. It saturates at all-ones and never wraps.
- Watchdog:
  - wd_cnt increments in RUN while stall != 0 and clears on any cycle with stall == 0.
  - PEND and FLUSH also clear wd_cnt.
  - When wd_cnt reaches TIMEOUT_CYC-1 with stall still non-zero, stall_timeout is set on the next edge.
  - stall_timeout stays set until rst.
- Reset mid-operation (PEND or FLUSH): on the next edge the FSM is in RUN and any pending redirect is discarded.

Decomposition:
- Shared defines file:
  - stall vector encodings (StallNone, StallIf, StallId, StallEx, StallMem, StallAll)
  - FSM state codes
  - ADDR_W default
  - NOP PC constant (ZeroWord)
- One natural sub-module: stall_prio_enc, the combinational 4-request-to-6-bit priority encoder. The FSM, counter and watchdog stay in pipe_ctrl.

Test Plan:
1. rst=1 held 3 cycles with every request high -> stall=0, flush=0, new_pc=0, stall_cycles=0 throughout. Release rst with no requests -> stall=0.
2. Request priority:
   - stallreq_id=1 and stallreq_if=1 together -> stall=6'b000111.
   - Add stallreq_mem=1 -> 6'b011111.
   - 5 cycles of stallreq_ex alone -> 6'b001111, and stall_cycles increases by 5.
3. excp_req=1 with excp_vec=32'h0000_0020 and stallreq_mem=0 at cycle N:
   - cycle N: stall=6'b111111.
   - cycle N+1: flush=1, new_pc=32'h20, stall=0.
   - cycle N+2: flush=0, back to RUN.
4. eret_req=1 with epc_i=32'h0000_1234 while stallreq_mem=1 for 4 cycles:
   - stall=6'b011111 for the 4 cycles.
   - A stray excp_req during PEND is ignored.
   - Flush cycle has new_pc=32'h1234, 1 cycle after stallreq_mem falls.
5. excp_req and eret_req in the same cycle (excp_vec=32'h20, epc_i=32'h40) -> new_pc=32'h20. Also: rst asserted during PEND -> no flush ever follows.
6. With TIMEOUT_CYC=8, hold stallreq_if for 8 cycles -> stall_timeout=1 after the 8th cycle, and it stays 1 after the request drops. A 7-cycle stall followed by a gap keeps stall_timeout=0.
